// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and handshake FSM states shared by alu_seq
package alu_pkg;
  localparam logic [3:0] OP_ADD = 4'h0, OP_INC = 4'h1, OP_SUB = 4'h2, OP_DEC = 4'h3;
  localparam logic [3:0] OP_MUL = 4'h4, OP_DIV = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7;
  localparam logic [3:0] OP_AND = 4'h8, OP_OR = 4'h9, OP_INV = 4'hA, OP_NAND = 4'hB;
  localparam logic [3:0] OP_NOR = 4'hC, OP_XOR = 4'hD, OP_XNOR = 4'hE, OP_BUF = 4'hF;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
endpackage

// File: rtl/alu_iter_muldiv.sv
// alu_iter_muldiv: one-bit-per-cycle shift-add multiplier and restoring divider
module alu_iter_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);
  logic div, ge;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] p, mc, p_n;
  logic [WIDTH-1:0] x, d, rem, x_n, rem_n;
  logic [WIDTH:0] r_sh;
  always_comb begin
    r_sh = {rem, x[WIDTH-1]};
    ge = r_sh >= {1'b0, d};
    rem_n = ge ? r_sh[WIDTH-1:0] - d : r_sh[WIDTH-1:0];
    p_n = x[0] ? p + mc : p;
    x_n = div ? {x[WIDTH-2:0], ge} : x >> 1;
  end
  assign done = busy && cnt == CW'(WIDTH - 1);
  assign result = div ? {rem_n, x_n} : p_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= '0;
      div <= op;
      p <= '0;
      mc <= {{WIDTH{1'b0}}, b};
      x <= a;
      d <= b;
      rem <= '0;
    end else if (busy) begin
      busy <= !done;
      cnt <= cnt + CW'(1);
      p <= p_n;
      mc <= mc << 1;
      x <= x_n;
      rem <= rem_n;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered 16-op ALU with valid/ready handshake and iterative mul/div
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         cmd,
  input  logic               en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] dout,
  output logic               zero,
  output logic               carry,
  output logic               dz
);
  localparam int DW = 2 * WIDTH;
  state_t state, state_n;
  logic accept, start, fin, load, en_r, cy, dzv, md_busy, md_done;
  logic [DW-1:0] ae, be, res, md_res, val;
  assign in_ready = state == IDLE && !md_busy && !rst;
  assign out_valid = state == DONE;
  assign accept = in_valid && in_ready;
  assign start = accept && (cmd == OP_MUL || (cmd == OP_DIV && b != '0));
  assign fin = (state == MUL || state == DIV) && md_done;
  assign load = (accept && !start) || fin;
  assign val = fin ? (en_r ? md_res : '0) : (en ? res : '0);
  alu_iter_muldiv #(.WIDTH(WIDTH)) u_md (
    .clk(clk), .rst(rst), .start(start), .op(cmd == OP_DIV), .a(a), .b(b),
    .busy(md_busy), .done(md_done), .result(md_res)
  );
  always_comb begin
    ae = {{WIDTH{1'b0}}, a};
    be = {{WIDTH{1'b0}}, b};
    case (cmd)
      OP_ADD:  res = ae + be;
      OP_INC:  res = ae + DW'(1);
      OP_SUB:  res = ae - be;
      OP_DEC:  res = ae - DW'(1);
      OP_DIV:  res = {a, {WIDTH{1'b1}}};
      OP_SHL:  res = ae << b;
      OP_SHR:  res = ae >> b;
      OP_AND:  res = ae & be;
      OP_OR:   res = ae | be;
      OP_INV:  res = ~ae;
      OP_NAND: res = ~(ae & be);
      OP_NOR:  res = ~(ae | be);
      OP_XOR:  res = ae ^ be;
      OP_XNOR: res = ~(ae ^ be);
      OP_BUF:  res = ae;
      default: res = '0;
    endcase
    cy = (cmd == OP_ADD || cmd == OP_INC) ? res[WIDTH] :
         cmd == OP_SUB ? a < b : cmd == OP_DEC ? a == '0 : 1'b0;
    dzv = cmd == OP_DIV && b == '0;
  end
  always_comb begin
    state_n = state;
    if (state == IDLE && accept) state_n = start ? (cmd == OP_MUL ? MUL : DIV) : DONE;
    if (fin) state_n = DONE;
    if (state == DONE && out_ready) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      dout <= '0;
      zero <= 1'b0;
      carry <= 1'b0;
      dz <= 1'b0;
      en_r <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) en_r <= en;
      if (load) begin
        dout <= val;
        zero <= val == '0;
        carry <= !fin && en && cy;
        dz <= !fin && en && dzv;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed checks of alu_seq against an arithmetic model
module tb_alu_seq;
  logic clk = 0, rst = 1, in_valid = 0, en = 0, out_ready = 0;
  logic [7:0] a = 0, b = 0;
  logic [3:0] cmd = 0;
  logic in_ready, out_valid, zero, carry, dz;
  logic [15:0] dout;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cmd(cmd), .en(en), .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
    .zero(zero), .carry(carry), .dz(dz)
  );
  function automatic logic [18:0] model(input logic [3:0] c, input logic [7:0] av, input logic [7:0] bv, input logic e);
    int unsigned x, y, r;
    logic cy, d;
    x = av;
    y = bv;
    r = 0;
    cy = 0;
    case (c)
      4'h0: begin r = x + y; cy = r >= 256; end
      4'h1: begin r = x + 1; cy = r >= 256; end
      4'h2: begin r = x - y; cy = x < y; end
      4'h3: begin r = x - 1; cy = x == 0; end
      4'h4: r = x * y;
      4'h5: r = y == 0 ? (x << 8) | 255 : ((x % y) << 8) | (x / y);
      4'h6: r = y >= 16 ? 0 : x << y;
      4'h7: r = y >= 16 ? 0 : x >> y;
      4'h8: r = x & y;
      4'h9: r = x | y;
      4'hA: r = ~x;
      4'hB: r = ~(x & y);
      4'hC: r = ~(x | y);
      4'hD: r = x ^ y;
      4'hE: r = ~(x ^ y);
      4'hF: r = x;
    endcase
    r = r & 32'hFFFF;
    d = c == 4'h5 && y == 0;
    if (!e) begin r = 0; cy = 0; d = 0; end
    return {d, cy, r == 0, r[15:0]};
  endfunction
  function automatic int lat_of(input logic [3:0] c, input logic [7:0] bv);
    return (c == 4'h4 || (c == 4'h5 && bv != 0)) ? 9 : 1;
  endfunction
  task automatic do_op(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y, input logic e,
                       output int lat, output bit rdy_seen);
    @(negedge clk);
    cmd = c; a = x; b = y; en = e; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    a = 8'($urandom); b = 8'($urandom); en = 1'($urandom);
    lat = 1;
    rdy_seen = 0;
    while (!out_valid && lat < 40) begin
      rdy_seen |= in_ready;
      @(posedge clk);
      #1 lat++;
    end
  endtask
  task automatic take();
    @(negedge clk) out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
  endtask
  task automatic test_reset();
    @(negedge clk);
    in_valid = 1; cmd = 4'h0; a = 8'd9; b = 8'd9; en = 1;
    repeat (3) @(posedge clk);
    #1 checks++;
    if ({out_valid, in_ready, zero, carry, dz, dout} !== 21'd0) begin
      errors++; $display("FAIL reset_state got ov=%b ir=%b z=%b c=%b dz=%b dout=%h want all 0",
                         out_valid, in_ready, zero, carry, dz, dout);
    end
    @(negedge clk) rst = 0; in_valid = 0;
    @(posedge clk);
    #1 checks++;
    if (in_ready !== 1 || out_valid !== 0) begin
      errors++; $display("FAIL reset_release got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
    end
  endtask
  task automatic test_directed();
    logic [3:0] tc [7] = '{4'h0, 4'h4, 4'h5, 4'h5, 4'h6, 4'h7, 4'h2};
    logic [7:0] ta [7] = '{8'd200, 8'd255, 8'd200, 8'd5, 8'h81, 8'h81, 8'd3};
    logic [7:0] tb [7] = '{8'd100, 8'd255, 8'd7, 8'd0, 8'd9, 8'd16, 8'd5};
    logic [15:0] td [7] = '{16'h012C, 16'hFE01, 16'h041C, 16'h05FF, 16'h0200, 16'h0000, 16'hFFFE};
    logic [18:0] exp;
    int lat;
    bit rs;
    for (int i = 0; i < 7; i++) begin
      do_op(tc[i], ta[i], tb[i], 1, lat, rs);
      exp = model(tc[i], ta[i], tb[i], 1);
      checks += 4;
      if (dout !== td[i]) begin
        errors++; $display("FAIL dir%0d_dout got %h want %h", i, dout, td[i]);
      end
      if ({dz, carry, zero} !== exp[18:16]) begin
        errors++; $display("FAIL dir%0d_flags got dz/c/z=%b want %b", i, {dz, carry, zero}, exp[18:16]);
      end
      if (lat != lat_of(tc[i], tb[i])) begin
        errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, lat_of(tc[i], tb[i]));
      end
      if (rs) begin
        errors++; $display("FAIL dir%0d_busy_ready got in_ready=1 while busy want 0", i);
      end
      take();
    end
  endtask
  task automatic test_random();
    logic [3:0] c;
    logic [7:0] x, y;
    logic e;
    logic [18:0] exp;
    int lat;
    bit rs;
    for (int i = 0; i < 80; i++) begin
      c = 4'($urandom_range(0, 15));
      x = 8'($urandom);
      y = $urandom_range(0, 2) == 0 ? 8'($urandom_range(0, 20)) : 8'($urandom);
      if (c == 4'h5 && $urandom_range(0, 3) == 0) y = 0;
      e = $urandom_range(0, 4) != 0;
      do_op(c, x, y, e, lat, rs);
      exp = model(c, x, y, e);
      checks += 3;
      if ({dz, carry, zero, dout} !== exp) begin
        errors++; $display("FAIL rand%0d op=%h a=%h b=%h en=%b got %h want %h", i, c, x, y, e,
                           {dz, carry, zero, dout}, exp);
      end
      if (lat != lat_of(c, y) || rs) begin
        errors++; $display("FAIL rand%0d_latency op=%h got %0d ready_seen=%b want %0d ready_seen=0",
                           i, c, lat, rs, lat_of(c, y));
      end
      take();
      if (in_ready !== 1 || out_valid !== 0) begin
        errors++; $display("FAIL rand%0d_return got ir=%b ov=%b want ir=1 ov=0", i, in_ready, out_valid);
      end
    end
  endtask
  task automatic test_backpressure();
    int lat;
    bit rs;
    do_op(4'hD, 8'hF0, 8'h3C, 1, lat, rs);
    checks++;
    if (dout !== 16'h00CC || lat != 1) begin
      errors++; $display("FAIL bp_result got dout=%h lat=%0d want 00cc lat=1", dout, lat);
    end
    @(negedge clk);
    in_valid = 1; cmd = 4'h0; a = 8'd1; b = 8'd1; en = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 checks++;
      if (dout !== 16'h00CC || out_valid !== 1 || in_ready !== 0) begin
        errors++; $display("FAIL bp_hold%0d got dout=%h ov=%b ir=%b want 00cc 1 0", i, dout, out_valid, in_ready);
      end
    end
    @(negedge clk) out_ready = 1; in_valid = 0;
    @(posedge clk);
    #1 out_ready = 0;
    checks++;
    if (in_ready !== 1 || out_valid !== 0) begin
      errors++; $display("FAIL bp_release got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
    end
    @(posedge clk);
    #1 checks++;
    if (out_valid !== 0 || dout !== 16'h00CC) begin
      errors++; $display("FAIL bp_no_extra got ov=%b dout=%h want ov=0 dout=00cc", out_valid, dout);
    end
  endtask
  task automatic test_reset_mid();
    int lat, ov_seen;
    bit rs;
    @(negedge clk);
    cmd = 4'h4; a = 8'd255; b = 8'd255; en = 1; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    @(posedge clk);
    @(negedge clk) rst = 1;
    @(posedge clk);
    #1 checks++;
    if (out_valid !== 0 || dout !== 16'h0000 || in_ready !== 0) begin
      errors++; $display("FAIL midrst_state got ov=%b dout=%h ir=%b want 0 0000 0", out_valid, dout, in_ready);
    end
    @(negedge clk) rst = 0;
    @(posedge clk);
    #1 checks++;
    if (in_ready !== 1) begin
      errors++; $display("FAIL midrst_ready got %b want 1", in_ready);
    end
    ov_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 ov_seen += out_valid;
    end
    checks++;
    if (ov_seen != 0) begin
      errors++; $display("FAIL midrst_abort got %0d valid cycles want 0", ov_seen);
    end
    do_op(4'h1, 8'hFF, 8'h00, 1, lat, rs);
    checks++;
    if (dout !== 16'h0100 || carry !== 1 || zero !== 0 || lat != 1) begin
      errors++; $display("FAIL midrst_inc got dout=%h c=%b z=%b lat=%0d want 0100 1 0 1", dout, carry, zero, lat);
    end
    take();
  endtask
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 16-op combinational ALU.
- Same 4-bit opcode set, with generic operand width WIDTH and a valid/ready handshake on both input and output.
- Mul and Div run on an iterative multi-cycle datapath; Div returns quotient and remainder.
- Adds status flags (zero, carry/borrow, divide-by-zero). Sits between an instruction-issue stage and a result writeback stage.

Parameters:
- WIDTH, 8, operand width in bits (>=2); result width is 2*WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand/command presented
- in_ready  out  1  block can accept a command
- a  in  WIDTH  operand A (unsigned)
- b  in  WIDTH  operand B (unsigned; shift amount for Shl/Shr)
- cmd  in  4  opcode
- en  in  1  result enable, captured with operands
- out_valid  out  1  result held on dout/flags
- out_ready  in  1  consumer takes the result
- dout  out  2*WIDTH  result
- zero  out  1  dout == 0
- carry  out  1  carry (Add/Inc) or borrow (Sub/Dec), else 0
- dz  out  1  Div with b == 0

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; dout, zero, carry, dz and out_valid go to 0.
  - in_ready is forced 0 while rst is high.
  - A reset mid-operation aborts the operation; no result is ever presented.
- Opcodes:
  - 0 Add, 1 Inc, 2 Sub, 3 Dec, 4 Mul, 5 Div, 6 Shl, 7 Shr
  - 8 And, 9 Or, A Inv, B Nand, C Nor, D Xor, E Xnor, F Buf
  - All 16 codes are defined; there is no illegal opcode.
- Width rules:
  - Operands are zero-extended to 2*WIDTH; arithmetic is modulo 2^(2*WIDTH). Example: Sub 3-5 gives all ones except LSB.
  - Logic ops act on the extended values, so Inv/Nand/Nor/Xnor set the upper WIDTH bits to 1.
  - Shl/Shr use the full value of b; b >= 2*WIDTH gives 0.
  - Mul gives the full 2*WIDTH product.
  - Div gives dout[WIDTH-1:0] = quotient and dout[2*WIDTH-1:WIDTH] = remainder.
- carry:
  - Add/Inc: carry = dout[WIDTH].
  - Sub/Dec: carry = (a < subtrahend).
  - All other ops: carry = 0.
- en = 0 at accept: dout = 0, zero = 1, carry = 0, dz = 0, with normal latency for the opcode.
- Handshake:
  - in_ready = (state == IDLE) && !rst.
  - Accept on in_valid && in_ready; a, b, cmd and en are registered at the accept edge.
  - Result is presented once out_valid = 1; dout and flags are stable until out_valid && out_ready.
  - in_valid is ignored while in_ready = 0.
- FSM:
  - IDLE -> MUL on accepting cmd 4.
  - IDLE -> DIV on accepting cmd 5 with b != 0.
  - IDLE -> DONE on accepting any other command, including Div with b == 0.
  - MUL/DIV: iteration counter runs 0..WIDTH-1, one bit per cycle (shift-add multiply, restoring divide); after count WIDTH-1 -> DONE.
  - DONE: out_valid = 1; on out_ready -> IDLE.
- Latency (accept edge to first cycle with out_valid = 1):
  - Single-cycle ops: 1 cycle.
  - Mul and Div (b != 0): WIDTH+1 cycles.
  - Throughput is at most one command per 2 cycles.
- Divide by zero: quotient = all ones, remainder = a, dz = 1, latency 1.
- Flags are registered together with dout and change only when entering DONE or on reset.

Decomposition:
- Package alu_pkg:
  - Opcode localparams Add..Buf with the encodings above.
  - FSM state encoding IDLE/MUL/DIV/DONE.
- Sub-module alu_iter_muldiv:
  - Inputs: start, op (mul/div), a, b.
  - Outputs: busy, done, 2*WIDTH result.
  - Holds the shift-add / restoring-divide registers and iteration counter.
- Top level (alu_seq) holds the handshake FSM, the single-cycle ops and the flags.

Test Plan (WIDTH=8):
- Add a=200, b=100, en=1 -> out_valid 1 cycle after accept; dout=0x012C, carry=1, zero=0.
- Mul a=255, b=255 -> out_valid exactly 9 cycles after accept; dout=0xFE01; in_ready=0 throughout.
- Div a=200, b=7 -> dout=0x041C (remainder 4, quotient 28), dz=0, latency 9. Div a=5, b=0 -> dout=0x05FF, dz=1, latency 1.
- Shl a=0x81, b=9 -> dout=0x0200. Shr a=0x81, b=16 -> dout=0, zero=1. Sub a=3, b=5 -> dout=0xFFFE, carry=1.
- Backpressure: complete Xor a=0xF0, b=0x3C, hold out_ready=0 for 5 cycles while driving in_valid -> dout=0x00CC stays stable, in_ready=0, no second command accepted. Assert out_ready -> back to IDLE next cycle.
- Assert rst on cycle 3 of a Mul -> next cycle out_valid=0, dout=0; in_ready=1 the cycle after rst drops. A following Inc a=0xFF -> dout=0x0100, carry=1.
